// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_e;

  localparam int unsigned MAX_MASTERS    = 8;
  localparam int unsigned MAX_DATA_WIDTH = 64;

  // Read data returned to a master whose transaction was aborted: the low 'width' bits set.
  function automatic logic [MAX_DATA_WIDTH-1:0] abort_data(input int unsigned width);
    logic [MAX_DATA_WIDTH-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_DATA_WIDTH; i++) begin
      v[i] = (i < width);
    end
    return v;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of master-side and wb_bus-side signals around wb_rr_arbiter.
// slave: the arbiter's view (it serves the masters); master: requesters plus bus model.
interface wb_rr_arbiter_if #(
  parameter int unsigned NUM_MASTERS   = 2,
  parameter int unsigned WB_DATA_WIDTH = 8,
  parameter int unsigned WB_ADDR_WIDTH = 16
);
  logic [NUM_MASTERS-1:0]               m_stb_i;
  logic [NUM_MASTERS-1:0]               m_we_i;
  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0] m_adr_i;
  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0] m_dat_i;
  logic [NUM_MASTERS-1:0]               m_ack_o;
  logic [WB_DATA_WIDTH-1:0]             m_dat_o;
  logic                                 s_stb_o;
  logic                                 s_we_o;
  logic [WB_ADDR_WIDTH-1:0]             s_adr_o;
  logic [WB_DATA_WIDTH-1:0]             s_dat_o;
  logic                                 s_ack_i;
  logic [WB_DATA_WIDTH-1:0]             s_dat_i;
  logic [NUM_MASTERS-1:0]               grant_o;
  logic                                 busy_o;
  logic                                 timeout_o;

  modport slave (
    input  m_stb_i, m_we_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    output m_ack_o, m_dat_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, grant_o, busy_o, timeout_o
  );

  modport master (
    output m_stb_i, m_we_i, m_adr_i, m_dat_i, s_ack_i, s_dat_i,
    input  m_ack_o, m_dat_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, grant_o, busy_o, timeout_o
  );
endinterface

// File: rtl/wb_rr_arbiter_pick.sv
// Combinational round-robin picker: first requester strictly after the one-hot 'last', wrapping.
module wb_rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] winner,
  output logic         any
);
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  int unsigned   base;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    base = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (last[k]) base = k;
    end
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      idx = IW'((base + off) % N);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign any = |req;
endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one transaction per grant onto the shared wb_bus master port.
// Optional ack timeout/abort enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned WB_DATA_WIDTH  = 8,
  parameter int unsigned WB_ADDR_WIDTH  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  wb_rr_arbiter_if.slave bus
);
  localparam logic [NUM_MASTERS-1:0] LAST_RST = {1'b1, {(NUM_MASTERS-1){1'b0}}};

  if (NUM_MASTERS < 2 || NUM_MASTERS > MAX_MASTERS || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("wb_rr_arbiter: unsupported parameter set");
  end

  arb_state_e               state_q;
  logic [NUM_MASTERS-1:0]   grant_q;
  logic [NUM_MASTERS-1:0]   last_q;
  logic                     busy_q;
  logic [NUM_MASTERS-1:0]   winner;
  logic                     any;
  logic                     req_held;
  logic                     abort;
  logic                     s_we;
  logic [WB_ADDR_WIDTH-1:0] s_adr;
  logic [WB_DATA_WIDTH-1:0] s_dat;

  wb_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req    (bus.m_stb_i),
    .last   (last_q),
    .winner (winner),
    .any    (any)
  );

  assign req_held = |(grant_q & bus.m_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q;
  // A real ack in the same cycle as the timeout takes precedence.
  assign abort = busy_q && (cnt_q == TW'(TIMEOUT_CYCLES)) && !bus.s_ack_i;
`else
  assign abort = 1'b0;
`endif

  // AND-OR mux: everything reads as zero while no grant is held.
  always_comb begin
    s_we  = 1'b0;
    s_adr = '0;
    s_dat = '0;
    for (int unsigned k = 0; k < NUM_MASTERS; k++) begin
      if (grant_q[k]) begin
        s_we  = bus.m_we_i[k];
        s_adr = bus.m_adr_i[k*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
        s_dat = bus.m_dat_i[k*WB_DATA_WIDTH +: WB_DATA_WIDTH];
      end
    end
  end

  assign bus.s_stb_o   = req_held & ~abort;
  assign bus.s_we_o    = s_we;
  assign bus.s_adr_o   = s_adr;
  assign bus.s_dat_o   = s_dat;
  assign bus.m_ack_o   = grant_q & {NUM_MASTERS{bus.s_ack_i | abort}};
  assign bus.m_dat_o   = abort  ? WB_DATA_WIDTH'(abort_data(WB_DATA_WIDTH)) :
                         busy_q ? bus.s_dat_i : '0;
  assign bus.grant_o   = grant_q;
  assign bus.busy_o    = busy_q;
  assign bus.timeout_o = abort;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      busy_q  <= 1'b0;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (any) begin
            state_q <= ARB_BUSY;
            grant_q <= winner;
            last_q  <= winner;
            busy_q  <= 1'b1;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ARB_BUSY: begin
          // Ack, timeout abort, or the master withdrawing its strobe all end the grant.
          if (bus.s_ack_i || !req_held || abort) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
          end
`ifdef WB_ARB_TIMEOUT_EN
          else begin
            cnt_q <= cnt_q + TW'(1);
          end
`endif
        end
        default: begin
          state_q <= ARB_IDLE;
          grant_q <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter; timeout steps follow WB_ARB_TIMEOUT_EN.
module tb_wb_rr_arbiter;
  localparam int unsigned N  = 2;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   tests  = 0;
  int   failed = 0;

  // Reference state: index of the master granted most recently.
  int exp_last = N - 1;

  logic [AW-1:0] adr_v [N];
  logic [DW-1:0] dat_v [N];
  logic          we_v  [N];

  wb_rr_arbiter_if #(.NUM_MASTERS(N), .WB_DATA_WIDTH(DW), .WB_ADDR_WIDTH(AW)) bus ();

  wb_rr_arbiter #(
    .NUM_MASTERS    (N),
    .WB_DATA_WIDTH  (DW),
    .WB_ADDR_WIDTH  (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next owner: scan masters in rotation order starting just after the last owner.
  function automatic int rr_next(input logic [N-1:0] mask);
    for (int off = 1; off <= int'(N); off++) begin
      if (mask[(exp_last + off) % N]) return (exp_last + off) % N;
    end
    return -1;
  endfunction

  task automatic drive_masters();
    for (int k = 0; k < int'(N); k++) begin
      bus.m_adr_i[k*AW +: AW] = adr_v[k];
      bus.m_dat_i[k*DW +: DW] = dat_v[k];
      bus.m_we_i[k]           = we_v[k];
    end
  endtask

  task automatic randomize_masters();
    for (int k = 0; k < int'(N); k++) begin
      adr_v[k] = AW'($urandom);
      dat_v[k] = DW'($urandom);
      we_v[k]  = 1'($urandom);
    end
  endtask

  // One full transaction: request in IDLE, grant, 'lat' wait cycles, ack with 'rd', back to IDLE.
  task automatic do_txn(input logic [N-1:0] mask, input int lat, input logic [DW-1:0] rd,
                        input string tag);
    int w;
    logic [N-1:0] oh;
    w  = rr_next(mask);
    oh = N'(1) << w;
    bus.m_stb_i = mask;
    drive_masters();
    @(posedge clk); #1;
    chk({tag, ":grant"}, 32'(bus.grant_o), 32'(oh));
    chk({tag, ":busy"},  32'(bus.busy_o), 32'd1);
    chk({tag, ":stb"},   32'(bus.s_stb_o), 32'd1);
    chk({tag, ":adr"},   32'(bus.s_adr_o), 32'(adr_v[w]));
    chk({tag, ":we"},    32'(bus.s_we_o), 32'(we_v[w]));
    chk({tag, ":wdat"},  32'(bus.s_dat_o), 32'(dat_v[w]));
    for (int c = 0; c < lat; c++) begin
      chk({tag, ":wait_ack"}, 32'(bus.m_ack_o), 32'd0);
      chk({tag, ":wait_to"},  32'(bus.timeout_o), 32'd0);
      @(posedge clk); #1;
      chk({tag, ":wait_stb"}, 32'(bus.s_stb_o), 32'd1);
    end
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = rd;
    #1;
    chk({tag, ":ack"},  32'(bus.m_ack_o), 32'(oh));
    chk({tag, ":rdat"}, 32'(bus.m_dat_o), 32'(rd));
    chk({tag, ":to"},   32'(bus.timeout_o), 32'd0);
    @(posedge clk); #1;
    bus.s_ack_i    = 1'b0;
    bus.s_dat_i    = DW'($urandom);
    bus.m_stb_i[w] = 1'b0;
    #1;
    chk({tag, ":idle_grant"}, 32'(bus.grant_o), 32'd0);
    chk({tag, ":idle_busy"},  32'(bus.busy_o), 32'd0);
    chk({tag, ":idle_ack"},   32'(bus.m_ack_o), 32'd0);
    exp_last = w;
  endtask

  initial begin
    int w;
    rst_n       = 1'b0;
    bus.m_stb_i = '0;
    bus.m_we_i  = '0;
    bus.m_adr_i = '0;
    bus.m_dat_i = '0;
    bus.s_ack_i = 1'b0;
    bus.s_dat_i = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    chk("rst:grant", 32'(bus.grant_o), 32'd0);
    chk("rst:busy",  32'(bus.busy_o), 32'd0);
    chk("rst:stb",   32'(bus.s_stb_o), 32'd0);
    chk("rst:we",    32'(bus.s_we_o), 32'd0);
    chk("rst:adr",   32'(bus.s_adr_o), 32'd0);
    chk("rst:sdat",  32'(bus.s_dat_o), 32'd0);
    chk("rst:ack",   32'(bus.m_ack_o), 32'd0);
    chk("rst:mdat",  32'(bus.m_dat_o), 32'd0);
    chk("rst:to",    32'(bus.timeout_o), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Both masters requesting from reset: grants alternate starting with master 0.
    for (int i = 0; i < 8; i++) begin
      randomize_masters();
      do_txn(2'b11, int'($urandom_range(0, 3)), DW'($urandom), "contend");
    end

    // Single read from master 0.
    randomize_masters();
    adr_v[0] = 16'hF000;
    we_v[0]  = 1'b0;
    do_txn(2'b01, 2, 8'hA9, "single");

    // Write forwarded from master 1; full ack vector checks keep master 0 at 0.
    randomize_masters();
    adr_v[1] = 16'h0085;
    dat_v[1] = 8'h5C;
    we_v[1]  = 1'b1;
    do_txn(2'b10, 1, DW'($urandom), "write");

    // Random request patterns and slave latencies.
    for (int i = 0; i < 24; i++) begin
      randomize_masters();
      do_txn(N'($urandom_range(1, (1 << N) - 1)), int'($urandom_range(0, 3)),
             DW'($urandom), "rand");
    end

    // Master withdraws its strobe while granted: grant ends, no ack.
    randomize_masters();
    drive_masters();
    w = rr_next(2'b11);
    bus.m_stb_i = 2'b11;
    @(posedge clk); #1;
    chk("drop:grant", 32'(bus.grant_o), 32'(N'(1) << w));
    bus.m_stb_i = '0;
    #1;
    chk("drop:stb", 32'(bus.s_stb_o), 32'd0);
    chk("drop:ack", 32'(bus.m_ack_o), 32'd0);
    @(posedge clk); #1;
    chk("drop:grant_clr", 32'(bus.grant_o), 32'd0);
    chk("drop:busy", 32'(bus.busy_o), 32'd0);
    exp_last = w;

`ifdef WB_ARB_TIMEOUT_EN
    // Slave never acks: abort on the fifth BUSY cycle.
    randomize_masters();
    drive_masters();
    w = rr_next(2'b01);
    bus.m_stb_i = 2'b01;
    @(posedge clk); #1;
    for (int c = 0; c < int'(TO); c++) begin
      chk("to:wait_ack", 32'(bus.m_ack_o), 32'd0);
      chk("to:wait_to",  32'(bus.timeout_o), 32'd0);
      chk("to:wait_stb", 32'(bus.s_stb_o), 32'd1);
      @(posedge clk); #1;
    end
    chk("to:ack",  32'(bus.m_ack_o), 32'(N'(1) << w));
    chk("to:mdat", 32'(bus.m_dat_o), 32'hFF);
    chk("to:pulse", 32'(bus.timeout_o), 32'd1);
    chk("to:stb",  32'(bus.s_stb_o), 32'd0);
    @(posedge clk); #1;
    bus.m_stb_i = '0;
    #1;
    chk("to:idle_grant", 32'(bus.grant_o), 32'd0);
    chk("to:idle_pulse", 32'(bus.timeout_o), 32'd0);
    exp_last = w;

    // Real ack landing on the timeout cycle wins.
    w = rr_next(2'b10);
    bus.m_stb_i = 2'b10;
    @(posedge clk); #1;
    repeat (TO) @(posedge clk);
    #1;
    bus.s_ack_i = 1'b1;
    bus.s_dat_i = 8'h3C;
    #1;
    chk("tocoin:ack",  32'(bus.m_ack_o), 32'(N'(1) << w));
    chk("tocoin:mdat", 32'(bus.m_dat_o), 32'h3C);
    chk("tocoin:to",   32'(bus.timeout_o), 32'd0);
    @(posedge clk); #1;
    bus.s_ack_i = 1'b0;
    bus.m_stb_i = '0;
    #1;
    chk("tocoin:idle", 32'(bus.grant_o), 32'd0);
    exp_last = w;
`else
    // Without the timeout the arbiter keeps waiting for the slave.
    randomize_masters();
    do_txn(2'b01, 12, DW'($urandom), "longwait");
`endif

    // Reset while BUSY: outputs drop immediately, priority returns to master 0.
    randomize_masters();
    drive_masters();
    w = rr_next(2'b11);
    bus.m_stb_i = 2'b11;
    @(posedge clk); #1;
    chk("rstmid:grant", 32'(bus.grant_o), 32'(N'(1) << w));
    bus.s_ack_i = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rstmid:stb",   32'(bus.s_stb_o), 32'd0);
    chk("rstmid:grant0", 32'(bus.grant_o), 32'd0);
    chk("rstmid:ack",   32'(bus.m_ack_o), 32'd0);
    chk("rstmid:busy",  32'(bus.busy_o), 32'd0);
    @(posedge clk); #1;
    bus.s_ack_i = 1'b0;
    rst_n = 1'b1;
    exp_last = N - 1;
    do_txn(2'b11, 1, DW'($urandom), "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/wb_rr_arbiter.md
# wb_rr_arbiter

Round-robin Wishbone arbiter that lets several bus masters share the single master port of the SoC's `wb_bus` interconnect. The arbiter sits between the masters and `wb_bus`. Typical masters are the `wb_6502_bridge` and a second requester such as a DMA or ROM loader. It grants one master at a time for exactly one transaction and forwards that master's strobe, write-enable, address and data to the bus. It returns ack and read data to the granted master, and can optionally abort transactions that a slave never acknowledges.

## Interface
- NUM_MASTERS, 2, number of requesting masters (2..8)
- WB_DATA_WIDTH, 8, data bus width
- WB_ADDR_WIDTH, 16, address bus width
- TIMEOUT_CYCLES, 255, cycles a granted transaction may wait for ack (used only with WB_ARB_TIMEOUT_EN)

Ports:
- clk_i  in  1  single system clock; all logic is rising-edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- m_stb_i  in  NUM_MASTERS  per-master request strobe
- m_we_i  in  NUM_MASTERS  per-master write enable
- m_adr_i  in  NUM_MASTERS*WB_ADDR_WIDTH  packed addresses; master k is at [k*AW +: AW]
- m_dat_i  in  NUM_MASTERS*WB_DATA_WIDTH  packed write data
- m_ack_o  out  NUM_MASTERS  ack, asserted only to the granted master
- m_dat_o  out  WB_DATA_WIDTH  read data, broadcast to all masters; valid when that master's ack is high
- s_stb_o, s_we_o  out  1  strobe and write enable to `wb_bus`
- s_adr_o  out  WB_ADDR_WIDTH  address to `wb_bus`
- s_dat_o  out  WB_DATA_WIDTH  write data to `wb_bus`
- s_ack_i  in  1  ack from `wb_bus`
- s_dat_i  in  WB_DATA_WIDTH  read data from `wb_bus`
- grant_o  out  NUM_MASTERS  one-hot registered grant; all zero when idle
- busy_o  out  1  high in BUSY
- timeout_o  out  1  one-cycle pulse when a transaction is aborted

## Operation
- The state machine has two states, IDLE and BUSY.
- IDLE:
  - If any m_stb_i is high, pick the first requester strictly after last_grant, searching in increasing index order and wrapping.
  - Register that master's one-hot code into grant_o and go to BUSY.
  - Load last_grant with the winner.
- BUSY:
  - s_stb_o, s_we_o, s_adr_o and s_dat_o are the combinational mux of the granted master's inputs.
  - m_ack_o[g] = s_ack_i. m_dat_o = s_dat_i.
- When s_ack_i is high in BUSY, clear grant_o and return to IDLE on the next edge.
- Exactly one transaction is carried per grant. There is no bus locking or bursting.
- A master that deasserts m_stb_i while granted, without an ack, ends the grant: the arbiter returns to IDLE and no ack is issued.
- Requests from non-granted masters are ignored until IDLE. Their m_ack_o stays 0.
- Masters must drop m_stb_i in the cycle after ack. The IDLE cycle that follows every transaction guarantees this.
- With all masters requesting continuously, grants rotate 0,1,…,N-1,0,…
- Reset values: state IDLE; grant_o, m_ack_o, s_stb_o, s_we_o, busy_o and timeout_o all 0; s_adr_o, s_dat_o and m_dat_o 0; last_grant = NUM_MASTERS-1, so master 0 wins first. The timeout counter resets to 0.
- Asserting rst_ni low mid-transaction drops s_stb_o and grant_o immediately. No ack is delivered.

## Timing
- Arbitration latency: a request in IDLE at edge N gives grant_o and s_stb_o high after edge N+1. Minimum transaction time is 2 cycles plus slave latency.
- The ack path from s_ack_i to m_ack_o is combinational, with zero added latency.
- Back-to-back throughput from one master: one transaction every (slave latency + 2) cycles.
- grant_o and busy_o are registered. The slave-side outputs are combinational from grant_o and the master inputs.

## Configuration
- Macro: WB_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the arbiter forces m_ack_o[g]=1 and m_dat_o = all ones for one cycle, drives s_stb_o=0 in that cycle, pulses timeout_o and returns to IDLE.
  - If s_ack_i and the timeout coincide, the real ack and data win and timeout_o stays 0.
- Undefined: the arbiter waits indefinitely for ack, timeout_o is tied 0, no counter is built, and the port list is unchanged.

## Structure
- Package `wb_arb_pkg`:
  - state enum {ARB_IDLE, ARB_BUSY}
  - a MAX_MASTERS=8 constant
  - an all-ones abort-data constant helper
- Sub-module `wb_rr_pick`: combinational round-robin picker with inputs req[N] and last one-hot[N], and outputs winner one-hot[N] and any.

## Test plan
- Single master: m_stb_i[0] pulses a read to 16'hF000; slave acks with 8'hA9 two cycles later → s_stb_o high from cycle 1, m_ack_o[0] coincident with s_ack_i, m_dat_o=8'hA9, grant_o=0 in the next cycle.
- Contention: both masters request from reset → master 0 granted first, master 1 granted after master 0's ack plus one IDLE cycle, and rotation continues 0,1,0,1 over 8 transactions.
- Write forwarding: master 1 writes 8'h5C to 16'h0085 → s_we_o=1, s_adr_o=16'h0085, s_dat_o=8'h5C; m_ack_o[0] stays 0 throughout.
- Timeout (macro on, TIMEOUT_CYCLES=4): slave never acks → after 4 BUSY cycles, one-cycle m_ack_o with m_dat_o=8'hFF, timeout_o pulses and the arbiter returns to IDLE. With an ack on cycle 4 instead → real data is returned and timeout_o=0.
- Reset mid-transaction: rst_ni driven low while BUSY → s_stb_o, grant_o and m_ack_o go to 0 asynchronously. After release, master 0 has priority again.
